// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: memory read port on one side, decoder handshake and redirect on the other.
interface instr_fetch_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic [7:0]  instr_byte0;
    logic [7:0]  instr_byte1;
    logic [7:0]  instr_byte2;
    logic [7:0]  instr_byte3;
    logic [2:0]  instr_len;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;

    modport master (
        output mem_addr, mem_rd,
        input  mem_rdata, mem_ready,
        output instr_byte0, instr_byte1, instr_byte2, instr_byte3,
        output instr_len, instr_pc, instr_valid,
        input  instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_addr, mem_rd,
        output mem_rdata, mem_ready,
        input  instr_byte0, instr_byte1, instr_byte2, instr_byte3,
        input  instr_len, instr_pc, instr_valid,
        output instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch: reads 1..4 bytes per instruction, decodes the length
// from the first two bytes and presents the assembled instruction to the decoder.
//
// state | meaning
// F0    | fetching byte 0 (opcode, ext flag)
// F1    | fetching byte 1 (mod / regA / regB)
// F2    | fetching byte 2
// F3    | fetching byte 3
// HOLD  | instruction presented, waiting for instr_ready
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);

    typedef enum logic [2:0] {F0, F1, F2, F3, HOLD} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pc;
    logic [15:0] instr_pc_q;
    logic [7:0]  byte0_q;
    logic [7:0]  byte1_q;
    logic [7:0]  byte2_q;
    logic [7:0]  byte3_q;
    logic [2:0]  len_q;
    logic [2:0]  len_f1;
    logic        run_q;
    logic        mem_rd_int;
    logic        valid_int;
    logic        xfer;
    logic        op_short;
    logic        restart;

    // Full length is known once byte 1 arrives; byte 0 is already captured by then.
    always_comb begin
        len_f1 = 3'd2;
        unique case (bus.mem_rdata[7:6])
            2'b01:   len_f1 = byte0_q[7] ? 3'd4 : 3'd3;
            2'b11:   len_f1 = 3'd4;
            default: len_f1 = 3'd2;
        endcase
    end

    assign op_short = (bus.mem_rdata[6:0] == 7'h00);
    assign xfer     = mem_rd_int && bus.mem_ready;
    assign restart  = bus.redirect || ((state == HOLD) && bus.instr_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= F0;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            F0:      if (xfer) state_nxt = op_short ? HOLD : F1;
            F1:      if (xfer) state_nxt = (len_f1 == 3'd2) ? HOLD : F2;
            F2:      if (xfer) state_nxt = (len_q == 3'd3) ? HOLD : F3;
            F3:      if (xfer) state_nxt = HOLD;
            HOLD:    if (bus.instr_ready) state_nxt = F0;
            default: state_nxt = F0;
        endcase
        if (bus.redirect) state_nxt = F0;
    end

    // run_q keeps mem_rd low while in reset and for nothing longer than that.
    always_comb begin
        mem_rd_int = run_q && (state != HOLD);
        valid_int  = (state == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q      <= 1'b0;
            pc         <= RESET_PC;
            instr_pc_q <= RESET_PC;
            byte0_q    <= 8'h00;
            byte1_q    <= 8'h00;
            byte2_q    <= 8'h00;
            byte3_q    <= 8'h00;
            len_q      <= 3'd1;
        end else begin
            run_q <= 1'b1;
            if (restart) begin
                byte0_q <= 8'h00;
                byte1_q <= 8'h00;
                byte2_q <= 8'h00;
                byte3_q <= 8'h00;
                len_q   <= 3'd1;
                if (bus.redirect) pc <= bus.redirect_pc;
            end else if (xfer) begin
                pc <= pc + 16'd1;
                unique case (state)
                    F0: begin
                        byte0_q    <= bus.mem_rdata;
                        instr_pc_q <= pc;
                        len_q      <= op_short ? 3'd1 : 3'd2;
                    end
                    F1: begin
                        byte1_q <= bus.mem_rdata;
                        len_q   <= len_f1;
                    end
                    F2:      byte2_q <= bus.mem_rdata;
                    F3:      byte3_q <= bus.mem_rdata;
                    default: ;
                endcase
            end
        end
    end

    assign bus.mem_addr    = pc;
    assign bus.mem_rd      = mem_rd_int;
    assign bus.instr_valid = valid_int;
    assign bus.instr_byte0 = byte0_q;
    assign bus.instr_byte1 = byte1_q;
    assign bus.instr_byte2 = byte2_q;
    assign bus.instr_byte3 = byte3_q;
    assign bus.instr_len   = len_q;
    assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory model, expected-instruction queue and a
// monitor that checks every presented instruction against it.
module tb_instr_fetch;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(16'hFFFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [0:65535];
    assign bus.mem_rdata = mem[bus.mem_addr];

    typedef struct packed {
        logic [31:0] bytes;
        logic [2:0]  len;
        logic [15:0] pc;
    } exp_t;

    exp_t        q[$];
    logic [15:0] model_pc;
    int          total = 0;
    int          bad   = 0;
    bit          prev_redirect = 1'b0;

    // Reference: decode the instruction starting at pc straight from memory contents.
    function automatic exp_t model(input logic [15:0] pc);
        exp_t       e;
        logic [7:0] b0;
        logic [7:0] b1;
        b0 = mem[pc];
        b1 = mem[pc + 16'd1];
        e.pc = pc;
        if (b0[6:0] == 7'h00)        e.len = 3'd1;
        else if (b1[7:6] == 2'b11)   e.len = 3'd4;
        else if (b1[7:6] == 2'b01)   e.len = b0[7] ? 3'd4 : 3'd3;
        else                         e.len = 3'd2;
        e.bytes = 32'h0;
        for (int i = 0; i < 4; i++)
            if (i < int'(e.len)) e.bytes[8*i +: 8] = mem[pc + 16'(i)];
        return e;
    endfunction

    task automatic topup();
        exp_t e;
        while (q.size() < 4) begin
            e = model(model_pc);
            q.push_back(e);
            model_pc = model_pc + 16'(e.len);
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_redirect = 1'b0;
        end else begin
            if (prev_redirect) check("redirect_drop", 64'(bus.instr_valid), 64'd0);
            if (!bus.redirect && bus.instr_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: got instr_pc %0h expected no instruction", bus.instr_pc);
                end else begin
                    check("instr_bytes",
                          64'({bus.instr_byte3, bus.instr_byte2, bus.instr_byte1, bus.instr_byte0}),
                          64'(q[0].bytes));
                    check("instr_len", 64'(bus.instr_len), 64'(q[0].len));
                    check("instr_pc", 64'(bus.instr_pc), 64'(q[0].pc));
                    check("hold_mem_rd", 64'(bus.mem_rd), 64'd0);
                    if (bus.instr_ready) void'(q.pop_front());
                end
            end
            prev_redirect = bus.redirect;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        topup();
    endtask

    task automatic do_redirect(input logic [15:0] addr);
        bus.redirect    = 1'b1;
        bus.redirect_pc = addr;
        q.delete();
        model_pc = addr;
        topup();
        tick();
        bus.redirect = 1'b0;
    endtask

    task automatic wait_valid(input int exp_cycles, input string name);
        int n = 0;
        while (!bus.instr_valid && n < 10) begin
            tick();
            n++;
        end
        check(name, 64'(n), 64'(exp_cycles));
    endtask

    task automatic accept();
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++)
            mem[i] = ($urandom % 5 == 0) ? 8'h00 : 8'($urandom);
        mem[16'hFFFF] = 8'h01; mem[16'h0000] = 8'h05;
        mem[16'h0100] = 8'h00; mem[16'h0101] = 8'h01; mem[16'h0102] = 8'h29;
        mem[16'h0200] = 8'h81; mem[16'h0201] = 8'h48; mem[16'h0202] = 8'hBE; mem[16'h0203] = 8'hEF;
        mem[16'h0300] = 8'h01; mem[16'h0301] = 8'h68; mem[16'h0302] = 8'h9B;

        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.mem_ready   = 1'b1;
        bus.instr_ready = 1'b0;
        q.delete();
        model_pc = 16'hFFFF;

        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_rd", 64'(bus.mem_rd), 64'd0);
        check("rst_valid", 64'(bus.instr_valid), 64'd0);
        check("rst_bytes", 64'({bus.instr_byte3, bus.instr_byte2, bus.instr_byte1, bus.instr_byte0}), 64'd0);
        check("rst_len", 64'(bus.instr_len), 64'd1);
        check("rst_instr_pc", 64'(bus.instr_pc), 64'hFFFF);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'hFFFF);

        @(negedge clk);
        rst = 1'b0;
        topup();
        tick();
        check("mem_rd_after_rst", 64'(bus.mem_rd), 64'd1);
        check("addr_after_rst", 64'(bus.mem_addr), 64'hFFFF);

        // Wrapping 2-byte instruction, then held for five cycles.
        wait_valid(2, "lat_wrap_len2");
        repeat (5) begin
            tick();
            check("hold_valid", 64'(bus.instr_valid), 64'd1);
        end
        accept();
        check("next_fetch_wrap", 64'(bus.mem_addr), 64'h0001);

        do_redirect(16'h0100);
        wait_valid(1, "lat_len1");
        accept();
        check("pc_after_len1", 64'(bus.mem_addr), 64'h0101);
        wait_valid(2, "lat_len2");
        accept();
        check("pc_after_len2", 64'(bus.mem_addr), 64'h0103);

        do_redirect(16'h0200);
        wait_valid(4, "lat_len4");
        accept();

        do_redirect(16'h0300);
        wait_valid(3, "lat_len3");
        accept();
        check("pc_after_len3", 64'(bus.mem_addr), 64'h0303);

        // Stall three cycles while fetching byte 1.
        do_redirect(16'h0101);
        tick();
        bus.mem_ready = 1'b0;
        repeat (3) begin
            tick();
            check("stall_addr", 64'(bus.mem_addr), 64'h0102);
            check("stall_valid", 64'(bus.instr_valid), 64'd0);
        end
        bus.mem_ready = 1'b1;
        wait_valid(1, "lat_after_stall");
        accept();

        // Redirect while fetching byte 2 of a 4-byte instruction.
        do_redirect(16'h0200);
        tick();
        tick();
        check("f2_addr", 64'(bus.mem_addr), 64'h0202);
        do_redirect(16'h2000);
        check("redir_addr", 64'(bus.mem_addr), 64'h2000);
        check("redir_valid", 64'(bus.instr_valid), 64'd0);

        for (int c = 0; c < 3000; c++) begin
            bus.mem_ready   = ($urandom % 4) != 0;
            bus.instr_ready = ($urandom % 2) != 0;
            bus.redirect    = 1'b0;
            if ($urandom % 40 == 0) begin
                bus.redirect    = 1'b1;
                bus.redirect_pc = 16'($urandom);
                q.delete();
                model_pc = bus.redirect_pc;
            end
            topup();
            tick();
        end
        bus.redirect    = 1'b0;
        bus.mem_ready   = 1'b1;
        bus.instr_ready = 1'b0;
        tick();

        // Asynchronous reset in the middle of an instruction.
        do_redirect(16'h0200);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_mem_rd", 64'(bus.mem_rd), 64'd0);
        check("midrst_valid", 64'(bus.instr_valid), 64'd0);
        check("midrst_bytes", 64'({bus.instr_byte3, bus.instr_byte2, bus.instr_byte1, bus.instr_byte0}), 64'd0);
        check("midrst_len", 64'(bus.instr_len), 64'd1);
        check("midrst_addr", 64'(bus.mem_addr), 64'hFFFF);
        q.delete();
        model_pc = 16'hFFFF;
        @(negedge clk);
        rst = 1'b0;
        topup();
        bus.instr_ready = 1'b1;
        repeat (30) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, address of the first fetch after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 mem_addr  output  16  byte address of the current memory read.
REQ-005 mem_rd  output  1  read request; held high with mem_addr stable until mem_ready.
REQ-006 mem_rdata  input  8  read data; valid in a cycle where mem_rd and mem_ready are both high.
REQ-007 mem_ready  input  1  memory completes the read in the current cycle.
REQ-008 instr_byte0..instr_byte3  output  8 each  assembled instruction bytes, in fetch order.
REQ-009 instr_len  output  3  instruction length in bytes (1..4).
REQ-010 instr_pc  output  16  address of instr_byte0.
REQ-011 instr_valid  output  1  assembled instruction is presented to the decoder.
REQ-012 instr_ready  input  1  decoder accepts the presented instruction.
REQ-013 redirect  input  1  discard in-flight fetch and restart at redirect_pc.
REQ-014 redirect_pc  input  16  restart address.

Function
REQ-015 The block SHALL use states F0, F1, F2, F3 (fetching byte 0..3) and HOLD (instruction presented).
REQ-016 A byte transfer SHALL occur only in a cycle with mem_rd=1 and mem_ready=1; the byte SHALL be captured into the slot for the current state, and pc SHALL increment by 1.
REQ-017 mem_rd SHALL be 1 in F0..F3 and 0 in HOLD; mem_addr SHALL equal pc.
REQ-018 Byte0 = {ext flag, opcode[6:0]}; byte1 = {mod[1:0], regA[2:0], regB[2:0]}.
REQ-019 Length: opcode 7'h00 gives 1, regardless of ext.
REQ-020 Length for mod 00 or 10 SHALL be 2; mod 01 SHALL be 3 if ext=0 and 4 if ext=1; mod 11 SHALL be 4.
REQ-021 Transitions: F0 goes to HOLD after a 1-byte opcode, otherwise to F1; F1 goes to HOLD at length 2, otherwise to F2; F2 goes to HOLD at length 3, otherwise to F3; F3 goes to HOLD.
REQ-022 Each transition SHALL occur only on a transfer; without mem_ready the state and captured bytes SHALL hold.
REQ-023 Unused byte slots (index >= instr_len) SHALL read 8'h00.
REQ-024 Slots SHALL be cleared on entry to F0.
REQ-025 instr_valid SHALL be 1 exactly while in HOLD; all instr_* outputs SHALL be stable while instr_valid=1.
REQ-026 HOLD with instr_ready=1 SHALL go to F0, with fetch continuing at the current pc (the address after the last byte).
REQ-027 instr_pc SHALL latch pc at the byte-0 transfer.
REQ-028 Latency with mem_ready tied high: an N-byte instruction SHALL take N fetch cycles, and instr_valid SHALL rise on the following cycle.
REQ-029 pc SHALL wrap 16'hFFFF to 16'h0000, including within an instruction.
REQ-030 On redirect=1 in any state, next state SHALL be F0 and pc SHALL be redirect_pc.
REQ-031 On redirect, captured bytes SHALL be discarded, and a transfer in the same cycle SHALL be ignored.
REQ-032 redirect SHALL override instr_ready in the same cycle; instr_valid SHALL drop next cycle.

Reset
REQ-033 While rst=1: state F0, pc=RESET_PC, instr_valid=0, instr_byte0..3=8'h00, instr_len=3'd1, instr_pc=RESET_PC.
REQ-034 mem_rd SHALL be 0 during rst and SHALL assert on the first clk edge after rst deasserts.
REQ-035 Reset asserted mid-instruction SHALL immediately abandon all partial state.

Verification
REQ-036 mem_ready=1, memory at 0: 00 | 01 29 -> first: instr_len=1, byte0=00, pc=0. Second: bytes 01 29 00 00, len=2, pc=1; valid on the 3rd cycle after F0 begins.
REQ-037 Memory 81 48 BE EF, instr_ready=1 -> len=4, bytes 81 48 BE EF.
REQ-038 Memory 01 68 9B, ext=0 -> len=3, bytes 01 68 9B 00.
REQ-039 mem_ready low for 3 cycles during byte1 -> mem_addr held at 1, state F1 held, result identical to the no-stall case.
REQ-040 instr_ready=0 for 5 cycles -> instr_valid stays 1, outputs stable, mem_rd=0.
REQ-041 redirect to 16'h2000 during F2 -> next mem_addr=2000, no instr_valid for the partial instruction.
REQ-042 RESET_PC=16'hFFFF, memory 01 at FFFF and 05 at 0000 -> bytes 01 05, len=2, instr_pc=FFFF, next fetch at 0001.
